instr_fetch: RTL

Instruction fetch unit for the RV32I core: owns the program counter, issues in-order word reads to instruction memory, buffers returned words with their PCs in a 2-entry queue, and presents them to the core's `instr` input through a valid/ready handshake. It sits between instruction memory and the `org` datapath, and supplies the `instr` stream that the core consumes. It accepts branch/jump redirects from the core.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core slice.
//   XLEN          : architectural register / PC width
//   PC_INC        : sequential fetch stride in bytes
//   RV_NOP        : canonical NOP encoding (addi x0, x0, 0)
//   fetch_state_e : instruction fetch FSM encoding
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous queue of {pc, instruction} pairs for the fetch unit.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data at the tail (ignored when full without a pop)
//   push_data  : {pc[31:0], instr[31:0]}
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the queue; wins over push and pop
//   full       : two entries held
//   empty      : no entries held
//   head       : oldest entry; stays stable until popped
module fetch_fifo (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [63:0] head
);

  logic [63:0] mem_q [2];
  logic        rd_q;
  logic        wr_q;
  logic [1:0]  cnt_q;
  logic        do_pop;
  logic        do_push;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted only if the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order word reads to
// instruction memory, buffers returned words with their PCs and hands them to
// the core over a valid/ready handshake. Accepts redirects from the core.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   mem_req_valid/addr/ready       : fetch request channel
//   mem_rsp_valid/data             : in-order read responses
//   instr_valid/instr/instr_pc     : queue head to the core
//   instr_ready                    : core consumes the head
//   redirect_valid/redirect_pc     : flush and restart fetch
//   misaligned_err                 : sticky, set by a misaligned redirect
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned_err
);

  localparam logic [2:0] CREDITS = 3'(DEPTH);

  fetch_state_e    state_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [1:0]      outstanding_q;
  logic [1:0]      outstanding_d;
  logic [1:0]      discard_q;
  logic [1:0]      discard_d;
  logic            err_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic [63:0]     fifo_head;
  logic [1:0]      count;
  logic [2:0]      in_use;
  logic            run;
  logic            pop;
  logic            accept;
  logic            keep;
  logic            flush;
  logic            redirect_ok;
  logic            redirect_bad;

  assign run   = (state_q == RUN);
  assign count = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pop   = instr_valid && instr_ready;

  // Credit check: every accepted request must find a queue slot when its
  // response returns. A head popped this cycle frees its slot immediately,
  // which is what lets zero-wait memory sustain one instruction per cycle.
  assign in_use = {1'b0, outstanding_q} + {1'b0, count} - {2'b00, pop};

  assign mem_req_valid = !reset && run && !redirect_valid && (in_use < CREDITS);
  assign mem_req_addr  = req_pc_q;
  assign accept        = mem_req_valid && mem_req_ready;

  assign redirect_ok  = run && redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = run && redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign flush        = redirect_ok || redirect_bad;

  // Responses are kept only in RUN, outside a redirect cycle, and once all
  // stale responses from before the last redirect have been dropped.
  assign keep = run && !redirect_valid && mem_rsp_valid && (discard_q == 2'd0);

  always_comb begin
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, mem_rsp_valid};
    discard_d     = discard_q;
    if (redirect_ok) begin
      // Everything still in flight after this cycle's response is stale.
      discard_d = outstanding_q - {1'b0, mem_rsp_valid};
    end else if (mem_rsp_valid && (discard_q != 2'd0)) begin
      discard_d = discard_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      req_pc_q      <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      case (state_q)
        RUN: begin
          discard_q <= discard_d;
          if (redirect_bad) begin
            state_q <= HALT;
            err_q   <= 1'b1;
          end else if (redirect_ok) begin
            req_pc_q <= redirect_pc;
            rsp_pc_q <= redirect_pc;
          end else begin
            if (accept) req_pc_q <= req_pc_q + PC_INC;
            if (keep)   rsp_pc_q <= rsp_pc_q + PC_INC;
          end
        end
        // HALT is left only through reset; responses just drain outstanding.
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data ({rsp_pc_q, mem_rsp_data}),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign instr_valid    = !fifo_empty;
  assign instr          = fifo_head[31:0];
  assign instr_pc       = fifo_head[63:32];
  assign misaligned_err = err_q;

endmodule
